// File: rtl/rand_arb_pkg.sv
// Shared types and defaults for the random-data round-robin arbiter.
// Optional statistics counter enabled with macro RAND_ARB_STATS_EN.
package rand_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arb_state_e;

   localparam int N_REQ_DEF   = 4;
   localparam int MIN_GAP_DEF = 3;
   localparam int GAP_W       = 4;
   localparam logic [7:0] CNT_MAX = 8'd255;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority select: first set request at or after the pointer.
// Purely combinational; wraps from N_REQ-1 back to 0.
module rr_pick
   import rand_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int PW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] Req,
   input  logic [PW-1:0]    Ptr,
   output logic [PW-1:0]    Idx,
   output logic             Valid
);

   int j;

   // Scan offsets from highest to lowest so the nearest hit wins.
   always_comb begin
      Idx   = '0;
      Valid = 1'b0;
      j     = 0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         j = (int'(Ptr) + i) % N_REQ;
         if (Req[j]) begin
            Idx   = PW'(j);
            Valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter issuing one-hot grant pulses with a random payload.
// Define RAND_ARB_STATS_EN to add the saturating GntCount output.
module rand_arbiter
   import rand_arb_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int MIN_GAP = MIN_GAP_DEF
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic [1:0]       Ran,
   input  logic [N_REQ-1:0] Req,
   output logic [N_REQ-1:0] Gnt,
   output logic [1:0]       Data,
   output logic             Busy
`ifdef RAND_ARB_STATS_EN
   ,
   output logic [7:0]       GntCount
`endif
);

   localparam int PW = $clog2(N_REQ);
   localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
   localparam logic [GAP_W-1:0] GAP_LOAD =
      (MIN_GAP > 0) ? GAP_W'(MIN_GAP - 1) : '0;

   arb_state_e       state_q, state_n;
   logic [PW-1:0]    ptr_q, ptr_n;
   logic [GAP_W-1:0] cnt_q, cnt_n;
   logic [N_REQ-1:0] gnt_q, gnt_n;
   logic [1:0]       data_q, data_n;
   logic             grant_entry;
   logic [PW-1:0]    pick_idx;
   logic             pick_vld;

   rr_pick #(
      .N_REQ (N_REQ),
      .PW    (PW)
   ) u_pick (
      .Req   (Req),
      .Ptr   (ptr_q),
      .Idx   (pick_idx),
      .Valid (pick_vld)
   );

   // State, pointer, gap counter and registered outputs.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_n;
         ptr_q   <= ptr_n;
         cnt_q   <= cnt_n;
         gnt_q   <= gnt_n;
         data_q  <= data_n;
      end
   end

   // Next-state and next-output logic; requests only matter in IDLE.
   always_comb begin
      state_n     = state_q;
      ptr_n       = ptr_q;
      cnt_n       = cnt_q;
      gnt_n       = '0;
      data_n      = data_q;
      grant_entry = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_n     = GRANT;
               gnt_n       = ONE << pick_idx;
               data_n      = Ran;
               grant_entry = 1'b1;
               if (pick_idx == PW'(N_REQ - 1))
                  ptr_n = '0;
               else
                  ptr_n = pick_idx + 1'b1;
            end
         end
         GRANT: begin
            if (MIN_GAP == 0) begin
               state_n = IDLE;
            end else begin
               state_n = GAP;
               cnt_n   = GAP_LOAD;
            end
         end
         GAP: begin
            if (cnt_q == '0)
               state_n = IDLE;
            else
               cnt_n = cnt_q - 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end

   assign Gnt  = gnt_q;
   assign Data = data_q;
   assign Busy = (state_q != IDLE);

`ifdef RAND_ARB_STATS_EN
   logic [7:0] stat_q;

   // Saturating count of grant entries.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset)
         stat_q <= '0;
      else if (grant_entry && stat_q != CNT_MAX)
         stat_q <= stat_q + 8'd1;
   end

   assign GntCount = stat_q;
`else
   logic unused_entry;
   assign unused_entry = grant_entry;
`endif

endmodule
